// File: rtl/as2650_io_arbiter.sv
// Two-master arbiter/sequencer for the internal 8-bit IO bus (CPU = m0, DMA/debug = m1).
// Define IO_ARB_ROUND_ROBIN_EN to alternate contended grants; default build is fixed priority to m0.
module as2650_io_arbiter #(
    parameter int WAIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       m0_req,
    input  logic       m0_we,
    input  logic [7:0] m0_addr,
    input  logic [7:0] m0_wdata,
    output logic [7:0] m0_rdata,
    output logic       m0_ack,
    input  logic       m1_req,
    input  logic       m1_we,
    input  logic [7:0] m1_addr,
    input  logic [7:0] m1_wdata,
    output logic [7:0] m1_rdata,
    output logic       m1_ack,
    output logic       bus_cyc,
    output logic       bus_we,
    output logic [7:0] bus_addr,
    output logic [7:0] bus_data_out,
    input  logic [7:0] bus_data_in,
    output logic       gnt
);

    // state    | meaning
    // ST_IDLE  | sample requests, grant a winner and latch its command
    // ST_CYCLE | bus_cyc high, wait counter runs down to terminal count 0
    // ST_ACK   | one-cycle ack to the owner, requests ignored

    generate
        if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
            $error("as2650_io_arbiter: WAIT_CYCLES must be in 1..15");
        end
    endgenerate

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CYCLE = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       winner;

    logic       bus_cyc_nxt, bus_we_nxt, gnt_nxt;
    logic [7:0] bus_addr_nxt, bus_data_out_nxt;
    logic       m0_ack_nxt, m1_ack_nxt;
    logic [7:0] m0_rdata_nxt, m1_rdata_nxt;

    // winner is only meaningful when at least one request is high
`ifdef IO_ARB_ROUND_ROBIN_EN
    always_comb begin
        winner = (m0_req && m1_req) ? ~gnt : ~m0_req;
    end
`else
    always_comb begin
        winner = ~m0_req;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            cnt          <= 4'd0;
            bus_cyc      <= 1'b0;
            bus_we       <= 1'b0;
            bus_addr     <= 8'h00;
            bus_data_out <= 8'h00;
            gnt          <= 1'b1;
            m0_ack       <= 1'b0;
            m1_ack       <= 1'b0;
            m0_rdata     <= 8'h00;
            m1_rdata     <= 8'h00;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            bus_cyc      <= bus_cyc_nxt;
            bus_we       <= bus_we_nxt;
            bus_addr     <= bus_addr_nxt;
            bus_data_out <= bus_data_out_nxt;
            gnt          <= gnt_nxt;
            m0_ack       <= m0_ack_nxt;
            m1_ack       <= m1_ack_nxt;
            m0_rdata     <= m0_rdata_nxt;
            m1_rdata     <= m1_rdata_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        cnt_nxt          = cnt;
        bus_cyc_nxt      = bus_cyc;
        bus_we_nxt       = bus_we;
        bus_addr_nxt     = bus_addr;
        bus_data_out_nxt = bus_data_out;
        gnt_nxt          = gnt;
        m0_ack_nxt       = 1'b0;
        m1_ack_nxt       = 1'b0;
        m0_rdata_nxt     = m0_rdata;
        m1_rdata_nxt     = m1_rdata;

        case (state)
            ST_IDLE: begin
                bus_cyc_nxt = 1'b0;
                bus_we_nxt  = 1'b0;
                if (m0_req || m1_req) begin
                    state_nxt        = ST_CYCLE;
                    cnt_nxt          = CNT_LOAD;
                    gnt_nxt          = winner;
                    bus_cyc_nxt      = 1'b1;
                    bus_we_nxt       = winner ? m1_we    : m0_we;
                    bus_addr_nxt     = winner ? m1_addr  : m0_addr;
                    bus_data_out_nxt = winner ? m1_wdata : m0_wdata;
                end
            end
            ST_CYCLE: begin
                if (cnt == 4'd0) begin
                    state_nxt   = ST_ACK;
                    bus_cyc_nxt = 1'b0;
                    bus_we_nxt  = 1'b0;
                    // bus_we still holds the latched direction of this transaction
                    if (gnt) begin
                        m1_ack_nxt = 1'b1;
                        if (!bus_we) m1_rdata_nxt = bus_data_in;
                    end else begin
                        m0_ack_nxt = 1'b1;
                        if (!bus_we) m0_rdata_nxt = bus_data_in;
                    end
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            ST_ACK: begin
                state_nxt   = ST_IDLE;
                bus_cyc_nxt = 1'b0;
                bus_we_nxt  = 1'b0;
            end
            default: begin
                state_nxt   = ST_IDLE;
                bus_cyc_nxt = 1'b0;
                bus_we_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_as2650_io_arbiter.sv
// Directed bench for as2650_io_arbiter: one instance with WAIT_CYCLES=1, one with WAIT_CYCLES=3.
module tb_as2650_io_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       m0_req, m0_we, m1_req, m1_we;
    logic [7:0] m0_addr, m0_wdata, m1_addr, m1_wdata, bus_data_in;

    logic [7:0] a_m0_rdata, a_m1_rdata, a_bus_addr, a_bus_data_out;
    logic       a_m0_ack, a_m1_ack, a_bus_cyc, a_bus_we, a_gnt;
    logic [7:0] b_m0_rdata, b_m1_rdata, b_bus_addr, b_bus_data_out;
    logic       b_m0_ack, b_m1_ack, b_bus_cyc, b_bus_we, b_gnt;

    int total = 0;
    int passed = 0;
    int fails = 0;
    int we_viol = 0;

    always #5 clk = ~clk;

    as2650_io_arbiter #(.WAIT_CYCLES(1)) u_dut_w1 (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(a_m0_rdata), .m0_ack(a_m0_ack),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(a_m1_rdata), .m1_ack(a_m1_ack),
        .bus_cyc(a_bus_cyc), .bus_we(a_bus_we), .bus_addr(a_bus_addr),
        .bus_data_out(a_bus_data_out), .bus_data_in(bus_data_in), .gnt(a_gnt)
    );

    as2650_io_arbiter #(.WAIT_CYCLES(3)) u_dut_w3 (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(b_m0_rdata), .m0_ack(b_m0_ack),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(b_m1_rdata), .m1_ack(b_m1_ack),
        .bus_cyc(b_bus_cyc), .bus_we(b_bus_we), .bus_addr(b_bus_addr),
        .bus_data_out(b_bus_data_out), .bus_data_in(bus_data_in), .gnt(b_gnt)
    );

    always @(negedge clk) begin
        if ((b_bus_we && !b_bus_cyc) || (a_bus_we && !a_bus_cyc)) we_viol++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s: observed %0b required %0b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s: observed 0x%02h required 0x%02h", tag, obs, exp);
        end
    endtask

    // Single-master transaction on the WAIT_CYCLES=3 instance, starting from IDLE.
    task automatic b_txn(input logic m, input logic we, input logic [7:0] addr,
                         input logic [7:0] wdata, input logic [7:0] din,
                         input logic [7:0] r0, input logic [7:0] r1);
        if (m) begin
            m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wdata;
        end else begin
            m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wdata;
        end
        bus_data_in = din;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1("txn_cyc", b_bus_cyc, 1'b1);
            chk1("txn_we", b_bus_we, we);
            chk8("txn_addr", b_bus_addr, addr);
            chk8("txn_dout", b_bus_data_out, wdata);
            chk1("txn_gnt", b_gnt, m);
            chk1("txn_early_ack", b_m0_ack | b_m1_ack, 1'b0);
        end
        tick();
        chk1("txn_ack0", b_m0_ack, ~m);
        chk1("txn_ack1", b_m1_ack, m);
        chk1("txn_cyc_end", b_bus_cyc, 1'b0);
        chk1("txn_we_end", b_bus_we, 1'b0);
        chk8("txn_rdata0", b_m0_rdata, r0);
        chk8("txn_rdata1", b_m1_rdata, r1);
        m0_req = 1'b0;
        m1_req = 1'b0;
        tick();
        chk1("txn_ack_drop", b_m0_ack | b_m1_ack, 1'b0);
        chk1("txn_idle_cyc", b_bus_cyc, 1'b0);
        chk8("txn_addr_hold", b_bus_addr, addr);
        chk8("txn_rdata0_hold", b_m0_rdata, r0);
        chk8("txn_rdata1_hold", b_m1_rdata, r1);
    endtask

    initial begin
        logic [3:0] rr_exp;
        logic       g;
        int         ack_cnt;
        int         cyc_cnt;

        rst = 1'b1;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = 8'h00; m0_wdata = 8'h00;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = 8'h00; m1_wdata = 8'h00;
        bus_data_in = 8'h00;
        tick();
        tick();
        rst = 1'b0;

        // reset values, both instances
        chk1("rst_a_cyc", a_bus_cyc, 1'b0);
        chk1("rst_a_we", a_bus_we, 1'b0);
        chk8("rst_a_addr", a_bus_addr, 8'h00);
        chk8("rst_a_dout", a_bus_data_out, 8'h00);
        chk1("rst_a_gnt", a_gnt, 1'b1);
        chk1("rst_a_ack", a_m0_ack | a_m1_ack, 1'b0);
        chk8("rst_a_rd0", a_m0_rdata, 8'h00);
        chk8("rst_a_rd1", a_m1_rdata, 8'h00);
        chk1("rst_b_cyc", b_bus_cyc, 1'b0);
        chk1("rst_b_gnt", b_gnt, 1'b1);
        chk8("rst_b_rd0", b_m0_rdata, 8'h00);

        // m0 read 0x45 on the WAIT_CYCLES=1 instance
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 8'h45; m0_wdata = 8'h11;
        bus_data_in = 8'hA5;
        tick();
        chk1("w1_cyc", a_bus_cyc, 1'b1);
        chk8("w1_addr", a_bus_addr, 8'h45);
        chk1("w1_we", a_bus_we, 1'b0);
        chk1("w1_gnt", a_gnt, 1'b0);
        chk1("w1_early_ack", a_m0_ack, 1'b0);
        tick();
        chk1("w1_cyc_end", a_bus_cyc, 1'b0);
        chk1("w1_ack0", a_m0_ack, 1'b1);
        chk8("w1_rdata0", a_m0_rdata, 8'hA5);
        chk1("w1_ack1", a_m1_ack, 1'b0);
        chk8("w1_rdata1", a_m1_rdata, 8'h00);
        m0_req = 1'b0;
        tick();
        chk1("w1_ack_drop", a_m0_ack, 1'b0);
        chk8("w1_rdata_hold", a_m0_rdata, 8'hA5);
        chk8("w1_addr_hold", a_bus_addr, 8'h45);

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // m1 read then m1 write on the WAIT_CYCLES=3 instance
        b_txn(1'b1, 1'b0, 8'h81, 8'h00, 8'h5A, 8'h00, 8'h5A);
        b_txn(1'b1, 1'b1, 8'hC2, 8'h3C, 8'hFF, 8'h00, 8'h5A);

        // both masters requesting continuously (writes), last owner is m1
`ifdef IO_ARB_ROUND_ROBIN_EN
        rr_exp = 4'b1010;
`else
        rr_exp = 4'b0000;
`endif
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 8'h10; m0_wdata = 8'h01;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 8'h90; m1_wdata = 8'h02;
        bus_data_in = 8'h00;
        for (int k = 0; k < 4; k++) begin
            g = rr_exp[k];
            tick();
            chk1("arb_gnt", b_gnt, g);
            chk1("arb_cyc", b_bus_cyc, 1'b1);
            chk8("arb_addr", b_bus_addr, g ? 8'h90 : 8'h10);
            tick();
            tick();
            tick();
            chk1("arb_ack0", b_m0_ack, ~g);
            chk1("arb_ack1", b_m1_ack, g);
            if (k == 3) begin
                m0_req = 1'b0;
                m1_req = 1'b0;
            end
            tick();
        end

        // master inputs changing mid-cycle are ignored
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 8'h4A; m0_wdata = 8'h00;
        bus_data_in = 8'h77;
        tick();
        chk1("mid_cyc", b_bus_cyc, 1'b1);
        chk8("mid_addr0", b_bus_addr, 8'h4A);
        chk1("mid_gnt0", b_gnt, 1'b0);
        m0_addr = 8'h00;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 8'hC9; m1_wdata = 8'h99;
        tick();
        chk8("mid_addr1", b_bus_addr, 8'h4A);
        chk1("mid_gnt1", b_gnt, 1'b0);
        chk1("mid_we", b_bus_we, 1'b0);
        tick();
        chk8("mid_addr2", b_bus_addr, 8'h4A);
        chk1("mid_m1_ack_early", b_m1_ack, 1'b0);
        tick();
        chk1("mid_ack0", b_m0_ack, 1'b1);
        chk8("mid_rdata0", b_m0_rdata, 8'h77);
        chk1("mid_ack1_none", b_m1_ack, 1'b0);
        chk1("mid_cyc_end", b_bus_cyc, 1'b0);
        m0_req = 1'b0;
        tick();
        chk1("mid_ack_gap", b_m0_ack | b_m1_ack, 1'b0);
        chk1("mid_gap_cyc", b_bus_cyc, 1'b0);
        tick();
        chk1("m1_after_cyc", b_bus_cyc, 1'b1);
        chk1("m1_after_gnt", b_gnt, 1'b1);
        chk8("m1_after_addr", b_bus_addr, 8'hC9);
        chk1("m1_after_we", b_bus_we, 1'b1);
        chk8("m1_after_dout", b_bus_data_out, 8'h99);
        tick();
        tick();
        tick();
        chk1("m1_after_ack", b_m1_ack, 1'b1);
        chk8("m1_after_rdata1", b_m1_rdata, 8'h5A);
        chk8("m1_after_rdata0", b_m0_rdata, 8'h77);
        m1_req = 1'b0;
        tick();

        // reset in the second bus cycle of a read
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 8'h13; m0_wdata = 8'h00;
        bus_data_in = 8'hEE;
        tick();
        tick();
        chk1("irq_cyc_before", b_bus_cyc, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk1("irq_cyc", b_bus_cyc, 1'b0);
        chk1("irq_we", b_bus_we, 1'b0);
        chk1("irq_ack", b_m0_ack | b_m1_ack, 1'b0);
        chk8("irq_rdata0", b_m0_rdata, 8'h00);
        chk8("irq_rdata1", b_m1_rdata, 8'h00);
        chk1("irq_gnt", b_gnt, 1'b1);
        chk8("irq_addr", b_bus_addr, 8'h00);
        b_txn(1'b0, 1'b0, 8'h13, 8'h00, 8'hEE, 8'hEE, 8'h00);

        // m0 holds req one cycle past ack: exactly one extra transaction
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 8'h05; m0_wdata = 8'h50;
        bus_data_in = 8'h00;
        tick();
        chk1("hs_cyc", b_bus_cyc, 1'b1);
        tick();
        tick();
        tick();
        chk1("hs_ack", b_m0_ack, 1'b1);
        tick();
        chk1("hs_ack_drop", b_m0_ack, 1'b0);
        chk1("hs_gap", b_bus_cyc, 1'b0);
        tick();
        chk1("hs_extra_cyc", b_bus_cyc, 1'b1);
        m0_req = 1'b0;
        ack_cnt = 0;
        cyc_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (b_m0_ack) ack_cnt++;
            if (b_bus_cyc) cyc_cnt++;
        end
        chk8("hs_extra_acks", 8'(ack_cnt), 8'd1);
        chk8("hs_extra_cyc_len", 8'(cyc_cnt), 8'd2);
        chk8("hs_rdata0", b_m0_rdata, 8'hEE);
        chk8("we_outside_cyc", 8'(we_viol), 8'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
